// File: rtl/dmem_stage_if.sv
// rtl/dmem_stage_if.sv - M-stage request and W-stage result bundle for dmem_stage
interface dmem_stage_if;
  logic [31:0] writeDataM;
  logic [31:0] ALUResultM;
  logic [4:0]  writeRegM;
  logic        regWriteM;
  logic        memWriteM;
  logic        mem2regM;
  logic [1:0]  memSizeM;
  logic        memUnsignedM;
  logic        zeroM;
  logic        branchM;
  logic [31:0] readDataW;
  logic [31:0] ALUResultW;
  logic [4:0]  writeRegW;
  logic        regWriteW;
  logic        mem2regW;
  logic        misalignW;
  logic        PCSrcM;
  logic        stallM;

  modport master (
    output writeDataM, ALUResultM, writeRegM, regWriteM, memWriteM, mem2regM,
           memSizeM, memUnsignedM, zeroM, branchM,
    input  readDataW, ALUResultW, writeRegW, regWriteW, mem2regW, misalignW,
           PCSrcM, stallM
  );

  modport slave (
    input  writeDataM, ALUResultM, writeRegM, regWriteM, memWriteM, mem2regM,
           memSizeM, memUnsignedM, zeroM, branchM,
    output readDataW, ALUResultW, writeRegW, regWriteW, mem2regW, misalignW,
           PCSrcM, stallM
  );
endinterface

// File: rtl/dmem_stage.sv
// rtl/dmem_stage.sv - memory stage: sized loads/stores, misalign check, multi-cycle stall, MEM/WB register
module dmem_stage #(
  parameter int DMEM_POWER = 18,
  parameter int LATENCY    = 1
) (
  input  logic         clk,
  input  logic         reset,
  dmem_stage_if.slave  bus
);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_WAIT   = 1'b1;
  localparam logic [2:0] CNT_LAST = 3'(LATENCY - 1);
  localparam logic       MULTI    = 1'(LATENCY > 1);

  logic [31:0] mem [2**DMEM_POWER];

  logic [DMEM_POWER-1:0] widx;
  logic [1:0]  lane;
  logic        access, is_byte, is_half, misalign, aligned_acc, complete;
  logic [31:0] rd_word, wr_word, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_addr_bits;

  logic [0:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d, alu_q, alu_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        regw_q, regw_d, m2r_q, m2r_d, mis_q, mis_d;

  // Upper address bits alias onto the RAM by design.
  assign widx             = bus.ALUResultM[DMEM_POWER+1:2];
  assign unused_addr_bits = ^bus.ALUResultM[31:DMEM_POWER+2];
  assign lane             = bus.ALUResultM[1:0];

  assign access      = bus.memWriteM | bus.mem2regM;
  assign is_byte     = (bus.memSizeM == 2'b00);
  assign is_half     = (bus.memSizeM == 2'b01);
  assign misalign    = access & ((is_half & lane[0]) |
                                 (~is_byte & ~is_half & (lane != 2'b00)));
  assign aligned_acc = access & ~misalign;

  // In WAIT cnt only runs 1..CNT_LAST, so inequality marks the stalling cycles.
  assign bus.stallM  = aligned_acc & MULTI &
                       ((state_q == S_IDLE) | (cnt_q != CNT_LAST));
  assign complete    = aligned_acc & ~bus.stallM;
  assign bus.PCSrcM  = bus.zeroM & bus.branchM;

  assign rd_word = mem[widx];

  always_comb begin
    wr_word = rd_word;
    if (is_byte) begin
      case (lane)
        2'd0:    wr_word[7:0]   = bus.writeDataM[7:0];
        2'd1:    wr_word[15:8]  = bus.writeDataM[7:0];
        2'd2:    wr_word[23:16] = bus.writeDataM[7:0];
        default: wr_word[31:24] = bus.writeDataM[7:0];
      endcase
    end else if (is_half) begin
      if (lane[1]) wr_word[31:16] = bus.writeDataM[15:0];
      else         wr_word[15:0]  = bus.writeDataM[15:0];
    end else begin
      wr_word = bus.writeDataM;
    end
  end

  always_comb begin
    case (lane)
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    if (is_byte)
      ld_data = {{24{~bus.memUnsignedM & ld_byte[7]}}, ld_byte};
    else if (is_half)
      ld_data = {{16{~bus.memUnsignedM & ld_half[15]}}, ld_half};
    else
      ld_data = rd_word;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (aligned_acc && MULTI) begin
          state_d = S_WAIT;
          cnt_d   = 3'd1;
        end
      end
      default: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 3'd1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end
      end
    endcase
  end

  // A stalled cycle pushes an all-zero bubble into W.
  always_comb begin
    rdata_d = '0;
    alu_d   = '0;
    wreg_d  = '0;
    regw_d  = 1'b0;
    m2r_d   = 1'b0;
    mis_d   = 1'b0;
    if (!bus.stallM) begin
      alu_d   = bus.ALUResultM;
      wreg_d  = bus.writeRegM;
      regw_d  = bus.regWriteM & ~misalign;
      m2r_d   = bus.mem2regM & ~misalign;
      mis_d   = misalign;
      rdata_d = (bus.mem2regM & ~misalign) ? ld_data : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= '0;
      alu_q   <= '0;
      wreg_q  <= '0;
      regw_q  <= 1'b0;
      m2r_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      wreg_q  <= wreg_d;
      regw_q  <= regw_d;
      m2r_q   <= m2r_d;
      mis_q   <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && complete && bus.memWriteM) begin
      mem[widx] <= wr_word;
    end
  end

  assign bus.readDataW  = rdata_q;
  assign bus.ALUResultW = alu_q;
  assign bus.writeRegW  = wreg_q;
  assign bus.regWriteW  = regw_q;
  assign bus.mem2regW   = m2r_q;
  assign bus.misalignW  = mis_q;
endmodule

// File: tb/tb_dmem_stage.sv
// tb/tb_dmem_stage.sv - randomized bench for dmem_stage at LATENCY 1 and 4 against a word-array model
module tb_dmem_stage;
  localparam int DP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        sel;
  logic [31:0] s_addr, s_wdata;
  logic [4:0]  s_wreg;
  logic [1:0]  s_size;
  logic        s_regw, s_we, s_rd, s_uns, s_zero, s_branch;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] ref_mem [2][16];

  dmem_stage_if bus1 ();
  dmem_stage_if bus4 ();

  dmem_stage #(.DMEM_POWER(DP), .LATENCY(1)) u_dut1 (.clk(clk), .reset(reset_n), .bus(bus1.slave));
  dmem_stage #(.DMEM_POWER(DP), .LATENCY(4)) u_dut4 (.clk(clk), .reset(reset_n), .bus(bus4.slave));

  assign bus1.writeDataM = s_wdata;      assign bus4.writeDataM = s_wdata;
  assign bus1.ALUResultM = s_addr;       assign bus4.ALUResultM = s_addr;
  assign bus1.writeRegM  = s_wreg;       assign bus4.writeRegM  = s_wreg;
  assign bus1.regWriteM  = s_regw;       assign bus4.regWriteM  = s_regw;
  assign bus1.memSizeM   = s_size;       assign bus4.memSizeM   = s_size;
  assign bus1.memUnsignedM = s_uns;      assign bus4.memUnsignedM = s_uns;
  assign bus1.zeroM      = s_zero;       assign bus4.zeroM      = s_zero;
  assign bus1.branchM    = s_branch;     assign bus4.branchM    = s_branch;
  assign bus1.memWriteM  = s_we & ~sel;  assign bus4.memWriteM  = s_we & sel;
  assign bus1.mem2regM   = s_rd & ~sel;  assign bus4.mem2regM   = s_rd & sel;

  wire [31:0] o_rdata = sel ? bus4.readDataW  : bus1.readDataW;
  wire [31:0] o_alu   = sel ? bus4.ALUResultW : bus1.ALUResultW;
  wire [4:0]  o_wreg  = sel ? bus4.writeRegW  : bus1.writeRegW;
  wire        o_regw  = sel ? bus4.regWriteW  : bus1.regWriteW;
  wire        o_m2r   = sel ? bus4.mem2regW   : bus1.mem2regW;
  wire        o_mis   = sel ? bus4.misalignW  : bus1.misalignW;
  wire        o_pcsrc = sel ? bus4.PCSrcM     : bus1.PCSrcM;
  wire        o_stall = sel ? bus4.stallM     : bus1.stallM;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                           input logic uns, input logic [1:0] a);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (w >> (8 * a)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] size, input logic [1:0] a);
    logic [31:0] mask;
    int sh;
    if (size == 2'd0)      begin sh = 8 * a;           mask = 32'hFF   << sh; end
    else if (size == 2'd1) begin sh = a[1] ? 16 : 0;   mask = 32'hFFFF << sh; end
    else                   begin sh = 0;               mask = 32'hFFFF_FFFF;  end
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  // Starts right after a posedge, returns right after the completion edge.
  task automatic run_op(input logic we, input logic rd, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] wreg, input logic regw);
    int lat, nstall, idx;
    logic acc, mis;
    logic [31:0] exp_ld;
    lat    = sel ? 4 : 1;
    acc    = we | rd;
    mis    = acc && ((size == 2'd1 && addr[0]) || (size[1] && addr[1:0] != 2'd0));
    nstall = (acc && !mis) ? lat - 1 : 0;
    idx    = int'(addr[DP+1:2]) % 16;
    exp_ld = ref_load(ref_mem[sel][idx], size, uns, addr[1:0]);
    s_we = we; s_rd = rd; s_size = size; s_uns = uns; s_addr = addr;
    s_wdata = wdata; s_wreg = wreg; s_regw = regw;
    s_zero = 1'($urandom_range(0, 1)); s_branch = 1'($urandom_range(0, 1));
    for (int c = 0; c < nstall; c++) begin
      @(negedge clk);
      check("stall_hi", o_stall, 1);
      @(posedge clk); #1;
      check("bubble_regw", o_regw, 0);
      check("bubble_m2r", o_m2r, 0);
    end
    @(negedge clk);
    check("stall_lo", o_stall, 0);
    check("pcsrc", o_pcsrc, s_zero & s_branch);
    @(posedge clk); #1;
    if (we && !mis) ref_mem[sel][idx] = ref_store(ref_mem[sel][idx], wdata, size, addr[1:0]);
    check("w_regw", o_regw, regw & ~mis);
    check("w_m2r", o_m2r, rd & ~mis);
    check("w_mis", o_mis, mis);
    check("w_alu", o_alu, addr);
    check("w_wreg", o_wreg, wreg);
    if (rd && !mis) check("w_rdata", o_rdata, exp_ld);
  endtask

  task automatic check_w_zero(input string tag);
    check({tag, "_regw"}, o_regw, 0);
    check({tag, "_m2r"}, o_m2r, 0);
    check({tag, "_mis"}, o_mis, 0);
    check({tag, "_wreg"}, o_wreg, 0);
    check({tag, "_alu"}, o_alu, 0);
    check({tag, "_rdata"}, o_rdata, 0);
  endtask

  initial begin
    logic [31:0] old30;
    sel = 1'b0; reset_n = 1'b0;
    s_addr = 0; s_wdata = 0; s_wreg = 0; s_size = 0;
    s_regw = 0; s_we = 0; s_rd = 0; s_uns = 0; s_zero = 0; s_branch = 0;
    repeat (2) @(posedge clk);
    #1;
    check_w_zero("rst1");
    sel = 1'b1;
    check_w_zero("rst4");
    reset_n = 1'b1;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 16; i++) run_op(1, 0, 2'd2, 0, 32'(i * 4), $urandom, 5'd0, 0);
    end

    sel = 1'b0;
    run_op(1, 0, 2'd2, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0);
    run_op(0, 1, 2'd2, 0, 32'h10, 32'h0, 5'd3, 1);
    check("l1_lw", o_rdata, 32'hDEADBEEF);
    run_op(1, 0, 2'd2, 0, 32'h20, 32'h80FF7F01, 5'd0, 0);
    run_op(0, 1, 2'd0, 0, 32'h21, 0, 5'd4, 1);  check("lb21", o_rdata, 32'h0000007F);
    run_op(0, 1, 2'd0, 0, 32'h22, 0, 5'd4, 1);  check("lb22", o_rdata, 32'hFFFFFFFF);
    run_op(0, 1, 2'd0, 1, 32'h23, 0, 5'd4, 1);  check("lbu23", o_rdata, 32'h00000080);
    run_op(0, 1, 2'd1, 0, 32'h22, 0, 5'd4, 1);  check("lh22", o_rdata, 32'hFFFF80FF);
    run_op(1, 0, 2'd0, 0, 32'h20, 32'h000000AA, 5'd0, 0);
    run_op(0, 1, 2'd2, 0, 32'h20, 0, 5'd4, 1);  check("sb_lw", o_rdata, 32'h80FF7FAA);

    old30 = ref_mem[0][12];
    run_op(0, 1, 2'd1, 0, 32'h31, 0, 5'd6, 1);  check("mis_lh", o_mis, 1);
    run_op(1, 0, 2'd2, 0, 32'h32, 32'h11111111, 5'd0, 0);
    run_op(0, 1, 2'd2, 0, 32'h30, 0, 5'd6, 1);  check("mis_sw_kept", o_rdata, old30);

    run_op(1, 0, 2'd2, 0, 32'(1 << (DP + 2)), 32'hCAFEF00D, 5'd0, 0);
    run_op(0, 1, 2'd2, 0, 32'h0, 0, 5'd1, 1);   check("wrap", o_rdata, 32'hCAFEF00D);

    sel = 1'b1;
    run_op(0, 1, 2'd2, 0, 32'h10, 0, 5'd9, 1);
    run_op(1, 0, 2'd2, 0, 32'h14, 32'h5A5A1234, 5'd0, 0);
    run_op(0, 1, 2'd2, 0, 32'h14, 0, 5'd9, 1);  check("l4_st_ld", o_rdata, 32'h5A5A1234);

    // Abort a LATENCY=4 store two cycles into its wait.
    s_we = 1; s_rd = 0; s_size = 2'd2; s_addr = 32'h18; s_wdata = ~ref_mem[1][6];
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; s_we = 0;
    check_w_zero("abort");
    run_op(0, 1, 2'd2, 0, 32'h18, 0, 5'd2, 1);

    sel = 1'b0;
    s_we = 0; s_rd = 0; s_regw = 1; s_wreg = 5'd7; s_addr = 32'h55; reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_w_zero("rst_nonacc");

    for (int n = 0; n < 160; n++) begin
      int kind;
      sel  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      run_op(kind == 2, kind == 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom & 32'hFFFF_FC3F, $urandom, 5'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dmem_stage.md
# dmem_stage

Parametrised memory stage of the pipelined CPU: performs data-memory loads/stores with byte/halfword/word sizes, sign/zero extension, misalignment detection and a configurable multi-cycle access latency. While an access is in progress it stalls the upstream pipeline. It registers its results into the MEM/WB pipeline register and computes the branch-taken signal.

## Interface
- DMEM_POWER, 18: log2 of data RAM depth in words; RAM = 2^DMEM_POWER × `WORD.
- LATENCY, 1: cycles per memory access, legal range 1..8; 1 = single-cycle access, no stall.
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- writeDataM  input  `WORD  store data; low bytes used for sb/sh.
- ALUResultM  input  `WORD  effective byte address; also forwarded to W.
- writeRegM  input  `REG_SIZE  destination register.
- regWriteM, memWriteM, mem2regM  input  1 each  control from E/M register.
- memSizeM  input  2  00 byte, 01 half, 10 word; 11 treated as word.
- memUnsignedM  input  1  1 = zero-extend loads, 0 = sign-extend.
- zeroM, branchM  input  1 each  branch condition inputs.
- readDataW  output  `WORD  extended load data.
- ALUResultW  output  `WORD  registered ALUResultM.
- writeRegW  output  `REG_SIZE  registered destination.
- regWriteW, mem2regW  output  1 each  registered controls.
- misalignW  output  1  access in W was misaligned and suppressed.
- PCSrcM  output  1  zeroM & branchM, combinational.
- stallM  output  1  combinational; freeze F/D/E/M registers this cycle.

## Operation
- access = memWriteM | mem2regM. Word index = ALUResultM[DMEM_POWER+1:2]; higher address bits ignored (wrap modulo RAM size).
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. A misaligned access performs no write, does not stall, and is registered into W with regWriteW=0, mem2regW=0, misalignW=1.
- Stores, little-endian byte enables: byte → lane addr[1:0] gets writeDataM[7:0]; half → lanes {addr[1],0} and {addr[1],1} get writeDataM[15:0]; word → all lanes. Unwritten lanes are preserved.
- Loads: RAM read is combinational on the word index. The byte or half at the lane selected as for stores is extended per memUnsignedM. Word loads are passed unchanged.
- FSM: IDLE, WAIT; cnt is a 3-bit counter.
  - IDLE: aligned access and LATENCY>1 → WAIT, cnt=1.
  - WAIT: cnt<LATENCY-1 → cnt+1; cnt==LATENCY-1 → IDLE, cnt=0.
- stallM = aligned access & LATENCY>1 & (state==IDLE | cnt<LATENCY-1).
- Completion cycle is the cycle with aligned access & stallM=0. The RAM write occurs and W registers capture the operation only on that cycle's edge.
- When stallM=1, W registers capture a bubble: regWriteW=0, mem2regW=0, writeRegW=0, misalignW=0, data=0.
- M-stage inputs are held stable by upstream while stallM=1. Behaviour with changing inputs is undefined.
- RAM contents are not reset.

## Timing
- Reset (reset=0 at posedge): state=IDLE, cnt=0, all W outputs 0. An access in progress is aborted with no write. PCSrcM and stallM are combinational and follow the inputs.
- Non-access or misaligned op: W valid 1 edge after entry, no stall.
- Aligned access: stallM high for the first LATENCY-1 cycles. Write and W capture happen at the edge ending cycle LATENCY. Stall bubbles occupy W during the wait.
- Back-to-back accesses: the next access's first cycle immediately follows the completion cycle and stalls again; there is no idle gap.
- A store followed by a load to the same word returns the new data, since the write lands before the load's completion cycle.

## Test plan
- LATENCY=1: sw 0xDEADBEEF @0x10, then lw @0x10 → readDataW=0xDEADBEEF, regWriteW=1, mem2regW=1, stallM never 1.
- Sizes: word 0x80FF7F01 @0x20. lb @0x21 → 0x0000007F; lb @0x22 → 0xFFFFFFFF; lbu @0x23 → 0x00000080; lh @0x22 → 0xFFFF80FF; sb 0xAA @0x20 then lw → 0x80FF7FAA.
- LATENCY=4: lw issued → stallM high 3 cycles, W bubbles (regWriteW=0) for 3 edges, data appears on the 4th edge. A following sw stalls 3 more cycles with no gap.
- Misalign: lh @0x31 → misalignW=1, regWriteW=0, no stall. sw @0x32 → RAM word @0x30 unchanged.
- Reset: LATENCY=4 sw in WAIT with cnt=2, reset=0 for 1 cycle → all W outputs 0, state IDLE, target word unchanged.
- Branch/wrap: zeroM=1, branchM=1 → PCSrcM=1 same cycle. sw @(1<<(DMEM_POWER+2)) aliases to word 0.
